dfi_init_seq: RTL and testbench



---
 rtl/dfi_init_seq.sv | 154 +++++++++++++++
 tb/tb_dfi_init_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dfi_init_seq.sv
// dfi_init_seq: DDR3 power-up and initialisation sequencer driving the DFI control interface
module dfi_init_seq #(
   parameter int C_DFI_FREQ_RATIO = 4,
   parameter int C_DFI_ADDR_WIDTH = 16,
   parameter int C_DFI_BANK_WIDTH = 3,
   parameter int C_DFI_CS_WIDTH   = 1,
   parameter int C_CMD_PHASE      = 0,
   parameter int C_RESET_CYCLES   = 50000,
   parameter int C_CKE_CYCLES     = 125000,
   parameter int C_TXPR           = 40,
   parameter int C_TMRD           = 2,
   parameter int C_TMOD           = 6,
   parameter int C_TZQINIT        = 128
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                start,
   input  logic [12:0]                                         mr0,
   input  logic [12:0]                                         mr1,
   input  logic [12:0]                                         mr2,
   input  logic [12:0]                                         mr3,
   output logic                                                dfi_init_start,
   input  logic                                                dfi_init_complete,
   output logic [C_DFI_CS_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]     dfi_reset_n,
   output logic [C_DFI_CS_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]     dfi_cke,
   output logic [C_DFI_CS_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]     dfi_odt,
   output logic [C_DFI_CS_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]     dfi_cs_n,
   output logic [0:0][C_DFI_FREQ_RATIO-1:0]                    dfi_ras_n,
   output logic [0:0][C_DFI_FREQ_RATIO-1:0]                    dfi_cas_n,
   output logic [0:0][C_DFI_FREQ_RATIO-1:0]                    dfi_we_n,
   output logic [C_DFI_BANK_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]   dfi_bank,
   output logic [C_DFI_ADDR_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]   dfi_address,
   output logic                                                busy,
   output logic                                                done
);
   localparam logic [2:0] IDLE = 3'd0, PHY_INIT = 3'd1, RST_LOW = 3'd2, CKE_LOW = 3'd3,
                          CKE_HIGH = 3'd4, MRS = 3'd5, ZQ = 3'd6, DONE = 3'd7;
   localparam int FR = C_DFI_FREQ_RATIO;
   localparam int AW = C_DFI_ADDR_WIDTH;
   localparam int BW = C_DFI_BANK_WIDTH;
   function automatic int mx(input int a, input int b);
      return a > b ? a : b;
   endfunction
   localparam int MAXW = mx(mx(mx(C_RESET_CYCLES, C_CKE_CYCLES), mx(C_TXPR, C_TMRD)), mx(C_TMOD, C_TZQINIT));
   localparam int W = MAXW > 1 ? $clog2(MAXW) : 1;
   localparam logic [W-1:0] L_RST = W'(C_RESET_CYCLES - 1);
   localparam logic [W-1:0] L_CKE = W'(C_CKE_CYCLES - 1);
   localparam logic [W-1:0] L_XPR = W'(C_TXPR - 1);
   localparam logic [W-1:0] L_MRD = W'(C_TMRD - 1);
   localparam logic [W-1:0] L_MOD = W'(C_TMOD - 1);
   localparam logic [W-1:0] L_ZQ  = W'(C_TZQINIT - 1);
   localparam logic [FR-1:0] PH = FR'(1) << C_CMD_PHASE;
   logic [2:0]    state;
   logic [W-1:0]  cnt;
   logic [1:0]    idx;
   logic          first;
   logic          mrs;
   logic          rn;
   logic          ck;
   logic [12:0]   mr;
   logic [AW-1:0] a;
   logic [BW-1:0] b;
   logic [FR-1:0] cph;
   logic [FR-1:0] rph;
   // command fields for the step in progress; idx 0..3 selects MR2, MR3, MR1, MR0
   always_comb begin
      mrs = state == MRS;
      rn  = state >= CKE_LOW;
      ck  = state >= CKE_HIGH;
      mr  = idx == 2'd0 ? mr2 : idx == 2'd1 ? mr3 : idx == 2'd2 ? mr1 : mr0;
      a   = mrs ? AW'(mr) : AW'(1) << 10;
      b   = mrs ? BW'({~idx[1], idx[1] ^ idx[0]}) : '0;
      cph = first ? ~PH : '1;
      rph = first && mrs ? ~PH : '1;
   end
   // sequencer: one shared down-counter times every state; first marks the command cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         first <= 1'b0;
      end else begin
         first <= 1'b0;
         case (state)
            IDLE, DONE: if (start) state <= PHY_INIT;
            PHY_INIT: if (dfi_init_complete) begin
               state <= RST_LOW;
               cnt   <= L_RST;
            end
            RST_LOW: if (cnt == '0) begin
               state <= CKE_LOW;
               cnt   <= L_CKE;
            end else cnt <= cnt - W'(1);
            CKE_LOW: if (cnt == '0) begin
               state <= CKE_HIGH;
               cnt   <= L_XPR;
            end else cnt <= cnt - W'(1);
            CKE_HIGH: if (cnt == '0) begin
               state <= MRS;
               cnt   <= L_MRD;
               idx   <= 2'd0;
               first <= 1'b1;
            end else cnt <= cnt - W'(1);
            MRS: if (cnt == '0) begin
               first <= 1'b1;
               if (idx == 2'd3) begin
                  state <= ZQ;
                  cnt   <= L_ZQ;
               end else begin
                  idx <= idx + 2'd1;
                  cnt <= idx == 2'd2 ? L_MOD : L_MRD;
               end
            end else cnt <= cnt - W'(1);
            default: if (cnt == '0) state <= DONE;
               else cnt <= cnt - W'(1);
         endcase
      end
   end
   // registered DFI outputs; reset_n/cke hold through PHY_INIT so a restart drops them only at RST_LOW
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dfi_init_start <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         dfi_reset_n    <= '0;
         dfi_cke        <= '0;
         dfi_odt        <= '0;
         dfi_cs_n       <= '1;
         dfi_ras_n      <= '1;
         dfi_cas_n      <= '1;
         dfi_we_n       <= '1;
         dfi_bank       <= '0;
         dfi_address    <= '0;
      end else begin
         dfi_init_start <= state != IDLE;
         busy           <= state != IDLE && state != DONE;
         done           <= state == DONE;
         dfi_odt        <= '0;
         if (state != PHY_INIT) begin
            dfi_reset_n <= {(C_DFI_CS_WIDTH * FR){rn}};
            dfi_cke     <= {(C_DFI_CS_WIDTH * FR){ck}};
         end
         dfi_cs_n  <= {C_DFI_CS_WIDTH{cph}};
         dfi_ras_n <= rph;
         dfi_cas_n <= rph;
         dfi_we_n  <= cph;
         if (first) begin
            for (int i = 0; i < AW; i++) dfi_address[i] <= {FR{a[i]}};
            for (int i = 0; i < BW; i++) dfi_bank[i] <= {FR{b[i]}};
         end
      end
   end
endmodule

// File: tb/tb_dfi_init_seq.sv
// tb_dfi_init_seq: directed table-driven checks of the DFI init sequencer
module tb_dfi_init_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, cpl = 1'b0, start1 = 1'b0, cpl1 = 1'b0;
   logic [12:0] mr0 = 13'h1D70, mr1 = 13'h0044, mr2 = 13'h0018, mr3 = 13'h0000;
   logic init_start, busy, done;
   logic [0:0][3:0] reset_n, cke, odt, cs_n, ras_n, cas_n, we_n;
   logic [2:0][3:0] bank;
   logic [15:0][3:0] addr;
   logic init_start1, busy1, done1;
   logic [1:0][3:0] reset_n1, cke1, odt1, cs_n1;
   logic [0:0][3:0] ras_n1, cas_n1, we_n1;
   logic [2:0][3:0] bank1;
   logic [15:0][3:0] addr1;
   int npass = 0, ntot = 0;
   typedef struct {
      int rel;
      logic rn, ck, bz, dn;
      logic [3:0] cs, ras, cas, we;
      logic [2:0] ba;
      logic [15:0] ad;
   } row_t;
   row_t tbl[$];

   always #5 clk = ~clk;

   dfi_init_seq #(.C_CMD_PHASE(1), .C_RESET_CYCLES(4), .C_CKE_CYCLES(5), .C_TXPR(3),
                  .C_TMRD(2), .C_TMOD(6), .C_TZQINIT(8)) u0 (
      .clk(clk), .rst(rst), .start(start), .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
      .dfi_init_start(init_start), .dfi_init_complete(cpl), .dfi_reset_n(reset_n),
      .dfi_cke(cke), .dfi_odt(odt), .dfi_cs_n(cs_n), .dfi_ras_n(ras_n), .dfi_cas_n(cas_n),
      .dfi_we_n(we_n), .dfi_bank(bank), .dfi_address(addr), .busy(busy), .done(done));

   dfi_init_seq #(.C_DFI_CS_WIDTH(2), .C_CMD_PHASE(0), .C_RESET_CYCLES(1), .C_CKE_CYCLES(1),
                  .C_TXPR(1), .C_TMRD(1), .C_TMOD(1), .C_TZQINIT(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
      .dfi_init_start(init_start1), .dfi_init_complete(cpl1), .dfi_reset_n(reset_n1),
      .dfi_cke(cke1), .dfi_odt(odt1), .dfi_cs_n(cs_n1), .dfi_ras_n(ras_n1), .dfi_cas_n(cas_n1),
      .dfi_we_n(we_n1), .dfi_bank(bank1), .dfi_address(addr1), .busy(busy1), .done(done1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [63:0] rep(input logic [15:0] v);
      logic [63:0] r = '0;
      for (int i = 0; i < 16; i++) r[i*4 +: 4] = {4{v[i]}};
      return r;
   endfunction

   task automatic add(input int rel, input logic rn, ck, bz, dn, input logic [3:0] cs, ras, cas, we,
                      input logic [2:0] ba, input logic [15:0] ad);
      row_t t;
      t.rel = rel; t.rn = rn; t.ck = ck; t.bz = bz; t.dn = dn;
      t.cs = cs; t.ras = ras; t.cas = cas; t.we = we; t.ba = ba; t.ad = ad;
      tbl.push_back(t);
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_rn"}, reset_n, 4'h0);
      chk({nm, "_cke"}, cke, 4'h0);
      chk({nm, "_odt"}, odt, 4'h0);
      chk({nm, "_cmd"}, {cs_n, ras_n, cas_n, we_n}, 16'hFFFF);
      chk({nm, "_ba"}, bank, 12'h0);
      chk({nm, "_ad"}, addr, 64'h0);
      chk({nm, "_flags"}, {init_start, busy, done}, 3'b000);
   endtask

   task automatic walk(input bit fresh, input bit abort, input bit poke);
      int j = 0, ncmd = 0;
      for (int r = 0; r <= 33; r++) begin
         if (r > 0) tick();
         if (cs_n != 4'hF) ncmd++;
         if (poke) start = r == 7;
         if (j < tbl.size() && tbl[j].rel == r) begin
            chk($sformatf("rn@%0d", r), reset_n, {4{tbl[j].rn}});
            chk($sformatf("cke@%0d", r), cke, {4{tbl[j].ck}});
            chk($sformatf("bsy_dn@%0d", r), {busy, done}, {tbl[j].bz, tbl[j].dn});
            chk($sformatf("cmd@%0d", r), {cs_n, ras_n, cas_n, we_n},
                {tbl[j].cs, tbl[j].ras, tbl[j].cas, tbl[j].we});
            chk($sformatf("ba@%0d", r), bank, rep({13'h0, tbl[j].ba}));
            if (fresh || r >= 13) chk($sformatf("ad@%0d", r), addr, rep(tbl[j].ad));
            j++;
         end
         if (abort && r == 18) begin
            rst = 1'b1;
            #1;
            chk_rst("midrst");
            rst = 1'b0;
            return;
         end
      end
      chk("ncmd", ncmd, 5);
   endtask

   task automatic run(input int gap, input bit fresh, input bit abort, input bit poke);
      cpl = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_k", busy, 1'b0);
      for (int i = 0; i < gap; i++) begin
         tick();
         chk("stall_flags", {init_start, busy, done}, 3'b110);
         chk("stall_cmd", cs_n, 4'hF);
         chk("stall_rn", {reset_n, cke}, {8{~fresh}});
      end
      cpl = 1'b1;
      tick();
      walk(fresh, abort, poke);
   endtask

   initial begin
      add(1,  0,0,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(4,  0,0,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(5,  1,0,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(9,  1,0,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(10, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(12, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0000);
      add(13, 1,1,1,0, 4'hD,4'hD,4'hD,4'hD, 3'd2, 16'h0018);
      add(14, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd2, 16'h0018);
      add(15, 1,1,1,0, 4'hD,4'hD,4'hD,4'hD, 3'd3, 16'h0000);
      add(16, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd3, 16'h0000);
      add(17, 1,1,1,0, 4'hD,4'hD,4'hD,4'hD, 3'd1, 16'h0044);
      add(18, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd1, 16'h0044);
      add(19, 1,1,1,0, 4'hD,4'hD,4'hD,4'hD, 3'd0, 16'h1D70);
      add(20, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h1D70);
      add(24, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h1D70);
      add(25, 1,1,1,0, 4'hD,4'hF,4'hF,4'hD, 3'd0, 16'h0400);
      add(26, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0400);
      add(32, 1,1,1,0, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0400);
      add(33, 1,1,0,1, 4'hF,4'hF,4'hF,4'hF, 3'd0, 16'h0400);
      repeat (3) tick();
      chk_rst("in_rst");
      rst = 1'b0;
      tick();
      chk_rst("idle");
      run(3, 1'b1, 1'b0, 1'b0);
      run(5, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      run(100, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      run(3, 1'b1, 1'b1, 1'b0);
      tick();
      run(3, 1'b1, 1'b0, 1'b0);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      cpl1 = 1'b1;
      tick();
      for (int r = 0; r <= 10; r++) begin
         logic [3:0] e_cs, e_ras, e_we;
         logic [2:0] e_ba;
         if (r > 0) tick();
         e_cs  = r >= 4 && r <= 8 ? 4'hE : 4'hF;
         e_ras = r >= 4 && r <= 7 ? 4'hE : 4'hF;
         e_we  = e_cs;
         e_ba  = r == 4 ? 3'd2 : r == 5 ? 3'd3 : r == 6 ? 3'd1 : 3'd0;
         chk($sformatf("r2_cs@%0d", r), cs_n1, {2{e_cs}});
         chk($sformatf("r2_cmd@%0d", r), {ras_n1, cas_n1, we_n1}, {e_ras, e_ras, e_we});
         chk($sformatf("r2_rn@%0d", r), reset_n1, {8{r >= 2}});
         chk($sformatf("r2_cke@%0d", r), cke1, {8{r >= 3}});
         chk($sformatf("r2_done@%0d", r), {busy1, done1}, {r < 9, r >= 9});
         if (r >= 4 && r <= 8) chk($sformatf("r2_ba@%0d", r), bank1, rep({13'h0, e_ba}));
      end
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
